// File: rtl/fetch_unit_if.sv
// Fetch unit bus: instruction-memory handshake, redirect inputs and decode-side outputs.
// The master modport is the fetch unit side; the slave modport is the memory/control side.
interface fetch_unit_if;
    logic [31:0] fetch_unit_mem_addr_out;
    logic        fetch_unit_mem_req_out;
    logic [31:0] fetch_unit_mem_data_in;
    logic        fetch_unit_mem_ack_in;
    logic        fetch_unit_redirect_in;
    logic [1:0]  fetch_unit_pc_src_in;
    logic [31:0] fetch_unit_target_in;
    logic        fetch_unit_ready_in;
    logic [31:0] fetch_unit_ir_out;
    logic [31:0] fetch_unit_pc_out;
    logic        fetch_unit_valid_out;
    logic        fetch_unit_misaligned_out;

    modport master (
        output fetch_unit_mem_addr_out, fetch_unit_mem_req_out,
               fetch_unit_ir_out, fetch_unit_pc_out,
               fetch_unit_valid_out, fetch_unit_misaligned_out,
        input  fetch_unit_mem_data_in, fetch_unit_mem_ack_in,
               fetch_unit_redirect_in, fetch_unit_pc_src_in,
               fetch_unit_target_in, fetch_unit_ready_in
    );

    modport slave (
        input  fetch_unit_mem_addr_out, fetch_unit_mem_req_out,
               fetch_unit_ir_out, fetch_unit_pc_out,
               fetch_unit_valid_out, fetch_unit_misaligned_out,
        output fetch_unit_mem_data_in, fetch_unit_mem_ack_in,
               fetch_unit_redirect_in, fetch_unit_pc_src_in,
               fetch_unit_target_in, fetch_unit_ready_in
    );
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit with redirect handling.
// Holds one fetched instruction for decode; in-flight words are drained, never re-addressed.
module fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter logic [31:0] NOP_INSN     = 32'h0000_0013
) (
    input  logic          fetch_unit_clock_in,
    input  logic          fetch_unit_reset_in,
    fetch_unit_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic        req_q, req_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        valid_q, valid_d;
    logic        mis_q, mis_d;

    logic        take_redirect;
    logic [31:0] raw_target;
    logic        target_misaligned;
    logic [31:0] new_target;

    always_comb begin
        take_redirect = bus.fetch_unit_redirect_in && (bus.fetch_unit_pc_src_in != 2'b00);
        raw_target    = TRAP_VECTOR;
        case (bus.fetch_unit_pc_src_in)
            2'b01:   raw_target = bus.fetch_unit_target_in;
            2'b10:   raw_target = {bus.fetch_unit_target_in[31:1], 1'b0};
            default: raw_target = TRAP_VECTOR;
        endcase
        target_misaligned = (raw_target[1:0] != 2'b00);
        new_target        = target_misaligned ? TRAP_VECTOR : raw_target;
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        addr_d   = addr_q;
        req_d    = req_q;
        ir_d     = ir_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;
        mis_d    = 1'b0;

        case (state_q)
            IDLE: begin
                addr_d  = pc_q;
                req_d   = 1'b1;
                state_d = FETCH;
            end
            FETCH: begin
                if (take_redirect) begin
                    pc_d  = new_target;
                    mis_d = target_misaligned;
                    // With ack the bus is free, so re-address now; otherwise the
                    // outstanding request must complete untouched in DRAIN.
                    if (bus.fetch_unit_mem_ack_in) begin
                        addr_d  = new_target;
                        req_d   = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (bus.fetch_unit_mem_ack_in) begin
                    ir_d     = bus.fetch_unit_mem_data_in;
                    pc_out_d = addr_q;
                    valid_d  = 1'b1;
                    pc_d     = pc_q + 32'd4;
                    req_d    = 1'b0;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (take_redirect) begin
                    valid_d = 1'b0;
                    ir_d    = NOP_INSN;
                    pc_d    = new_target;
                    addr_d  = new_target;
                    mis_d   = target_misaligned;
                    req_d   = 1'b1;
                    state_d = FETCH;
                end else if (bus.fetch_unit_ready_in) begin
                    valid_d = 1'b0;
                    ir_d    = NOP_INSN;
                    addr_d  = pc_q;
                    req_d   = 1'b1;
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                if (take_redirect) begin
                    pc_d  = new_target;
                    mis_d = target_misaligned;
                end
                if (bus.fetch_unit_mem_ack_in) begin
                    addr_d  = take_redirect ? new_target : pc_q;
                    req_d   = 1'b1;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge fetch_unit_clock_in or posedge fetch_unit_reset_in) begin
        if (fetch_unit_reset_in) begin
            state_q  <= IDLE;
            pc_q     <= RESET_VECTOR;
            addr_q   <= RESET_VECTOR;
            req_q    <= 1'b0;
            ir_q     <= NOP_INSN;
            pc_out_q <= '0;
            valid_q  <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            req_q    <= req_d;
            ir_q     <= ir_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
            mis_q    <= mis_d;
        end
    end

    assign bus.fetch_unit_mem_addr_out   = addr_q;
    assign bus.fetch_unit_mem_req_out    = req_q;
    assign bus.fetch_unit_ir_out         = ir_q;
    assign bus.fetch_unit_pc_out         = pc_out_q;
    assign bus.fetch_unit_valid_out      = valid_q;
    assign bus.fetch_unit_misaligned_out = mis_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: inputs driven and outputs checked on the falling edge.
module tb_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    fetch_unit_if bus();

    fetch_unit #(
        .RESET_VECTOR(32'h0000_0000),
        .TRAP_VECTOR (32'h0000_0100),
        .NOP_INSN    (32'h0000_0013)
    ) dut (
        .fetch_unit_clock_in(clk),
        .fetch_unit_reset_in(rst),
        .bus                (bus)
    );

    always #5 clk = ~clk;

    task automatic wait_req(input logic [31:0] exp_addr, input string name);
        int n = 0;
        while (bus.fetch_unit_mem_req_out !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.fetch_unit_mem_req_out !== 1'b1 || bus.fetch_unit_mem_addr_out !== exp_addr) begin
            errors++;
            $display("FAIL %s: req=%b addr=%h, required req=1 addr=%h", name,
                     bus.fetch_unit_mem_req_out, bus.fetch_unit_mem_addr_out, exp_addr);
        end
    endtask

    task automatic test_reset();
        bus.fetch_unit_mem_data_in = '0;
        bus.fetch_unit_mem_ack_in  = 1'b0;
        bus.fetch_unit_redirect_in = 1'b0;
        bus.fetch_unit_pc_src_in   = 2'b00;
        bus.fetch_unit_target_in   = '0;
        bus.fetch_unit_ready_in    = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.fetch_unit_mem_req_out !== 1'b0 || bus.fetch_unit_valid_out !== 1'b0 ||
            bus.fetch_unit_ir_out !== NOP || bus.fetch_unit_pc_out !== 32'h0 ||
            bus.fetch_unit_mem_addr_out !== 32'h0 || bus.fetch_unit_misaligned_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: req=%b valid=%b ir=%h pc_out=%h addr=%h mis=%b, required 0 0 %h 0 0 0",
                     bus.fetch_unit_mem_req_out, bus.fetch_unit_valid_out, bus.fetch_unit_ir_out,
                     bus.fetch_unit_pc_out, bus.fetch_unit_mem_addr_out, bus.fetch_unit_misaligned_out, NOP);
        end
        rst = 1'b0;
        @(negedge clk);
        wait_req(32'h0, "first_req");
    endtask

    task automatic test_basic();
        bus.fetch_unit_mem_ack_in  = 1'b1;
        bus.fetch_unit_mem_data_in = 32'h0050_0093;
        @(negedge clk);
        bus.fetch_unit_mem_ack_in  = 1'b0;
        bus.fetch_unit_mem_data_in = '0;
        checks++;
        if (bus.fetch_unit_valid_out !== 1'b1 || bus.fetch_unit_ir_out !== 32'h0050_0093 ||
            bus.fetch_unit_pc_out !== 32'h0 || bus.fetch_unit_mem_req_out !== 1'b0) begin
            errors++;
            $display("FAIL basic_hold: valid=%b ir=%h pc_out=%h req=%b, required 1 00500093 0 0",
                     bus.fetch_unit_valid_out, bus.fetch_unit_ir_out, bus.fetch_unit_pc_out,
                     bus.fetch_unit_mem_req_out);
        end
        bus.fetch_unit_ready_in = 1'b1;
        @(negedge clk);
        bus.fetch_unit_ready_in = 1'b0;
        checks++;
        if (bus.fetch_unit_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL basic_valid_drop: valid=%b, required 0", bus.fetch_unit_valid_out);
        end
        wait_req(32'h4, "basic_next_req");
    endtask

    task automatic test_hold_stall();
        bus.fetch_unit_mem_ack_in  = 1'b1;
        bus.fetch_unit_mem_data_in = 32'h00A0_0113;
        @(negedge clk);
        bus.fetch_unit_mem_ack_in  = 1'b0;
        bus.fetch_unit_redirect_in = 1'b1;
        bus.fetch_unit_pc_src_in   = 2'b00;
        bus.fetch_unit_target_in   = 32'h0000_0200;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.fetch_unit_valid_out !== 1'b1 || bus.fetch_unit_ir_out !== 32'h00A0_0113 ||
                bus.fetch_unit_pc_out !== 32'h4 || bus.fetch_unit_mem_req_out !== 1'b0) begin
                errors++;
                $display("FAIL stall_cycle%0d: valid=%b ir=%h pc_out=%h req=%b, required 1 00a00113 4 0", i,
                         bus.fetch_unit_valid_out, bus.fetch_unit_ir_out, bus.fetch_unit_pc_out,
                         bus.fetch_unit_mem_req_out);
            end
            @(negedge clk);
        end
        bus.fetch_unit_redirect_in = 1'b0;
        bus.fetch_unit_ready_in    = 1'b1;
        @(negedge clk);
        bus.fetch_unit_ready_in = 1'b0;
        wait_req(32'h8, "stall_next_req");
    endtask

    task automatic test_redirect_fetch();
        bus.fetch_unit_redirect_in = 1'b1;
        bus.fetch_unit_pc_src_in   = 2'b01;
        bus.fetch_unit_target_in   = 32'h0000_0080;
        @(negedge clk);
        bus.fetch_unit_redirect_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (bus.fetch_unit_mem_req_out !== 1'b1 || bus.fetch_unit_mem_addr_out !== 32'h8) begin
                errors++;
                $display("FAIL drain_hold%0d: req=%b addr=%h, required 1 00000008", i,
                         bus.fetch_unit_mem_req_out, bus.fetch_unit_mem_addr_out);
            end
            @(negedge clk);
        end
        bus.fetch_unit_mem_ack_in  = 1'b1;
        bus.fetch_unit_mem_data_in = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.fetch_unit_mem_ack_in = 1'b0;
        checks++;
        if (bus.fetch_unit_valid_out !== 1'b0 || bus.fetch_unit_ir_out !== NOP) begin
            errors++;
            $display("FAIL drain_discard: valid=%b ir=%h, required 0 %h",
                     bus.fetch_unit_valid_out, bus.fetch_unit_ir_out, NOP);
        end
        wait_req(32'h80, "drain_next_req");
        // Redirect coinciding with ack: re-address immediately, word discarded.
        bus.fetch_unit_redirect_in = 1'b1;
        bus.fetch_unit_pc_src_in   = 2'b11;
        bus.fetch_unit_mem_ack_in  = 1'b1;
        @(negedge clk);
        bus.fetch_unit_redirect_in = 1'b0;
        bus.fetch_unit_mem_ack_in  = 1'b0;
        checks++;
        if (bus.fetch_unit_valid_out !== 1'b0 || bus.fetch_unit_mem_req_out !== 1'b1 ||
            bus.fetch_unit_mem_addr_out !== 32'h100) begin
            errors++;
            $display("FAIL trap_with_ack: valid=%b req=%b addr=%h, required 0 1 00000100",
                     bus.fetch_unit_valid_out, bus.fetch_unit_mem_req_out, bus.fetch_unit_mem_addr_out);
        end
    endtask

    task automatic test_redirect_hold();
        bus.fetch_unit_mem_ack_in  = 1'b1;
        bus.fetch_unit_mem_data_in = 32'h0020_0093;
        @(negedge clk);
        bus.fetch_unit_mem_ack_in  = 1'b0;
        bus.fetch_unit_redirect_in = 1'b1;
        bus.fetch_unit_pc_src_in   = 2'b10;
        bus.fetch_unit_target_in   = 32'h0000_0101;
        bus.fetch_unit_ready_in    = 1'b1;
        @(negedge clk);
        bus.fetch_unit_redirect_in = 1'b0;
        bus.fetch_unit_ready_in    = 1'b0;
        checks++;
        if (bus.fetch_unit_valid_out !== 1'b0 || bus.fetch_unit_ir_out !== NOP ||
            bus.fetch_unit_mem_req_out !== 1'b1 || bus.fetch_unit_mem_addr_out !== 32'h100 ||
            bus.fetch_unit_misaligned_out !== 1'b0) begin
            errors++;
            $display("FAIL jr_in_hold: valid=%b ir=%h req=%b addr=%h mis=%b, required 0 %h 1 00000100 0",
                     bus.fetch_unit_valid_out, bus.fetch_unit_ir_out, bus.fetch_unit_mem_req_out,
                     bus.fetch_unit_mem_addr_out, bus.fetch_unit_misaligned_out, NOP);
        end
        bus.fetch_unit_mem_ack_in  = 1'b1;
        bus.fetch_unit_mem_data_in = 32'h0030_0193;
        @(negedge clk);
        bus.fetch_unit_mem_ack_in = 1'b0;
        checks++;
        if (bus.fetch_unit_valid_out !== 1'b1 || bus.fetch_unit_pc_out !== 32'h100) begin
            errors++;
            $display("FAIL trap_fetch_hold: valid=%b pc_out=%h, required 1 00000100",
                     bus.fetch_unit_valid_out, bus.fetch_unit_pc_out);
        end
        bus.fetch_unit_redirect_in = 1'b1;
        bus.fetch_unit_pc_src_in   = 2'b01;
        bus.fetch_unit_target_in   = 32'h0000_0102;
        @(negedge clk);
        bus.fetch_unit_redirect_in = 1'b0;
        checks++;
        if (bus.fetch_unit_misaligned_out !== 1'b1 || bus.fetch_unit_valid_out !== 1'b0 ||
            bus.fetch_unit_mem_req_out !== 1'b1 || bus.fetch_unit_mem_addr_out !== 32'h100) begin
            errors++;
            $display("FAIL misaligned_pulse: mis=%b valid=%b req=%b addr=%h, required 1 0 1 00000100",
                     bus.fetch_unit_misaligned_out, bus.fetch_unit_valid_out,
                     bus.fetch_unit_mem_req_out, bus.fetch_unit_mem_addr_out);
        end
        @(negedge clk);
        checks++;
        if (bus.fetch_unit_misaligned_out !== 1'b0 || bus.fetch_unit_mem_addr_out !== 32'h100) begin
            errors++;
            $display("FAIL misaligned_one_cycle: mis=%b addr=%h, required 0 00000100",
                     bus.fetch_unit_misaligned_out, bus.fetch_unit_mem_addr_out);
        end
    endtask

    task automatic test_wrap();
        bus.fetch_unit_redirect_in = 1'b1;
        bus.fetch_unit_pc_src_in   = 2'b01;
        bus.fetch_unit_target_in   = 32'hFFFF_FFFC;
        bus.fetch_unit_mem_ack_in  = 1'b1;
        @(negedge clk);
        bus.fetch_unit_redirect_in = 1'b0;
        bus.fetch_unit_mem_ack_in  = 1'b0;
        wait_req(32'hFFFF_FFFC, "wrap_req");
        bus.fetch_unit_mem_ack_in  = 1'b1;
        bus.fetch_unit_mem_data_in = 32'h0040_0213;
        @(negedge clk);
        bus.fetch_unit_mem_ack_in = 1'b0;
        checks++;
        if (bus.fetch_unit_valid_out !== 1'b1 || bus.fetch_unit_pc_out !== 32'hFFFF_FFFC ||
            bus.fetch_unit_ir_out !== 32'h0040_0213) begin
            errors++;
            $display("FAIL wrap_hold: valid=%b pc_out=%h ir=%h, required 1 fffffffc 00400213",
                     bus.fetch_unit_valid_out, bus.fetch_unit_pc_out, bus.fetch_unit_ir_out);
        end
        bus.fetch_unit_ready_in = 1'b1;
        @(negedge clk);
        bus.fetch_unit_ready_in = 1'b0;
        wait_req(32'h0, "wrap_next_req");
    endtask

    task automatic test_reset_drain();
        bus.fetch_unit_mem_ack_in  = 1'b1;
        bus.fetch_unit_mem_data_in = 32'h0050_0293;
        @(negedge clk);
        bus.fetch_unit_mem_ack_in = 1'b0;
        bus.fetch_unit_ready_in   = 1'b1;
        @(negedge clk);
        bus.fetch_unit_ready_in = 1'b0;
        wait_req(32'h4, "pre_drain_req");
        bus.fetch_unit_redirect_in = 1'b1;
        bus.fetch_unit_pc_src_in   = 2'b01;
        bus.fetch_unit_target_in   = 32'h0000_0040;
        @(negedge clk);
        bus.fetch_unit_redirect_in = 1'b0;
        checks++;
        if (bus.fetch_unit_mem_req_out !== 1'b1 || bus.fetch_unit_mem_addr_out !== 32'h4) begin
            errors++;
            $display("FAIL in_drain: req=%b addr=%h, required 1 00000004",
                     bus.fetch_unit_mem_req_out, bus.fetch_unit_mem_addr_out);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.fetch_unit_mem_req_out !== 1'b0 || bus.fetch_unit_valid_out !== 1'b0 ||
            bus.fetch_unit_mem_addr_out !== 32'h0 || bus.fetch_unit_ir_out !== NOP) begin
            errors++;
            $display("FAIL async_reset: req=%b valid=%b addr=%h ir=%h, required 0 0 0 %h",
                     bus.fetch_unit_mem_req_out, bus.fetch_unit_valid_out,
                     bus.fetch_unit_mem_addr_out, bus.fetch_unit_ir_out, NOP);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        // Redirect while IDLE must be ignored.
        bus.fetch_unit_redirect_in = 1'b1;
        bus.fetch_unit_pc_src_in   = 2'b01;
        bus.fetch_unit_target_in   = 32'h0000_0080;
        @(negedge clk);
        bus.fetch_unit_redirect_in = 1'b0;
        checks++;
        if (bus.fetch_unit_mem_req_out !== 1'b1 || bus.fetch_unit_mem_addr_out !== 32'h0) begin
            errors++;
            $display("FAIL post_reset_req: req=%b addr=%h, required 1 00000000",
                     bus.fetch_unit_mem_req_out, bus.fetch_unit_mem_addr_out);
        end
        bus.fetch_unit_mem_ack_in  = 1'b1;
        bus.fetch_unit_mem_data_in = 32'h0060_0313;
        @(negedge clk);
        bus.fetch_unit_mem_ack_in = 1'b0;
        checks++;
        if (bus.fetch_unit_valid_out !== 1'b1 || bus.fetch_unit_pc_out !== 32'h0 ||
            bus.fetch_unit_ir_out !== 32'h0060_0313) begin
            errors++;
            $display("FAIL post_reset_hold: valid=%b pc_out=%h ir=%h, required 1 0 00600313",
                     bus.fetch_unit_valid_out, bus.fetch_unit_pc_out, bus.fetch_unit_ir_out);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_hold_stall();
        test_redirect_fetch();
        test_redirect_hold();
        test_wrap();
        test_reset_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter TRAP_VECTOR, default 32'h0000_0100: target for pc_src 2'b11 and for misaligned redirects.
REQ-003 Parameter NOP_INSN, default 32'h0000_0013: IR value while no instruction is held.
REQ-004 fetch_unit_clock_in  in  1: single clock; all state updates on its rising edge.
REQ-005 fetch_unit_reset_in  in  1: reset, asynchronous and active-high.
REQ-006 fetch_unit_mem_addr_out  out  32: instruction memory address, registered.
REQ-007 fetch_unit_mem_req_out  out  1: fetch request, registered.
REQ-008 fetch_unit_mem_data_in  in  32: instruction word, valid when ack=1.
REQ-009 fetch_unit_mem_ack_in  in  1: one-cycle completion pulse for the outstanding request.
REQ-010 fetch_unit_redirect_in  in  1: control-flow change request from control/datapath.
REQ-011 fetch_unit_pc_src_in  in  2: redirect source; 00 none, 01 branch, 10 jump-register, 11 trap.
REQ-012 fetch_unit_target_in  in  32: computed branch/jump target.
REQ-013 fetch_unit_ready_in  in  1: decode stage accepts the held instruction.
REQ-014 fetch_unit_ir_out  out  32: held instruction (IR).
REQ-015 fetch_unit_pc_out  out  32: address of the held instruction.
REQ-016 fetch_unit_valid_out  out  1: IR/pc_out hold a valid instruction.
REQ-017 fetch_unit_misaligned_out  out  1: one-cycle pulse on a misaligned redirect.

Function
REQ-018 FSM states IDLE, FETCH, HOLD, DRAIN; internal next-fetch register PC (32 bits) separate from mem_addr_out.
REQ-019 IDLE: req=0, valid=0; always moves to FETCH next cycle, mem_addr_out<=PC, req<=1.
REQ-020 FETCH: req=1 and mem_addr_out stable until ack; on ack: IR<=mem_data_in, pc_out<=mem_addr_out, valid<=1, PC<=PC+4, req<=0, -> HOLD.
REQ-021 HOLD: valid=1, IR/pc_out stable; on ready_in=1: valid<=0, mem_addr_out<=PC, req<=1, -> FETCH (one instruction per >=2 cycles).
REQ-022 PC+4 is modulo 2^32: 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-023 Redirect (redirect_in=1 and pc_src!=00) is taken in FETCH, HOLD and DRAIN, ignored in IDLE; pc_src=00 with redirect_in=1 is a no-op.
REQ-024 New target: 01 -> target_in; 10 -> {target_in[31:1],1'b0}; 11 -> TRAP_VECTOR.
REQ-025 Misaligned target (bits[1:0]!=0 after REQ-024 masking) -> PC<=TRAP_VECTOR, misaligned_out=1 for exactly that next cycle.
REQ-026 Redirect in HOLD: valid<=0, IR<=NOP_INSN, PC<=new target, mem_addr_out<=new target, req<=1, -> FETCH; ready_in same cycle ignored.
REQ-027 Redirect in FETCH with ack same cycle: fetched word discarded, valid stays 0, PC/mem_addr_out<=new target, req=1, -> FETCH.
REQ-028 Redirect in FETCH without ack: PC<=new target, req and mem_addr_out held, -> DRAIN.
REQ-029 DRAIN: req=1, address unchanged; on ack word discarded, mem_addr_out<=PC, -> FETCH; a further redirect in DRAIN only overwrites PC.
REQ-030 Memory never sees an address change while req=1 and no ack has arrived.

Reset
REQ-031 While reset=1: state=IDLE, PC=RESET_VECTOR, mem_addr_out=RESET_VECTOR, req=0, valid=0, IR=NOP_INSN, pc_out=0, misaligned=0.
REQ-032 Reset mid-operation aborts any request and discards any held or in-flight word; the first request after release is to RESET_VECTOR.

Verification
REQ-033 Release reset, ack 1 cycle after req, data 32'h0050_0093, ready=1 -> req addr 0x0, IR=0x00500093 pc_out=0x0 valid 1 cycle, next req addr 0x4.
REQ-034 ready=0 for 5 cycles in HOLD -> IR/pc_out/valid stable, req=0; ready=1 -> next req at pc_out+4.
REQ-035 Redirect pc_src=01 target 0x80 during FETCH, ack 3 cycles later -> addr held until ack, word discarded (valid=0), next req addr 0x80.
REQ-036 Redirect pc_src=10 target 0x101 in HOLD -> valid drops, next req 0x100; pc_src=01 target 0x102 -> misaligned pulse 1 cycle, next req 0x100 (TRAP_VECTOR).
REQ-037 PC reaching 0xFFFF_FFFC, fetch completes -> next req addr 0x0000_0000.
REQ-038 Assert reset during DRAIN with req=1 -> req=0, valid=0 immediately; after release first req addr RESET_VECTOR.
